// File: rtl/rearrange_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rearrange_pkg
// Description : Shared mode type and mode constants for the stream rearranger.
// Revision    : 1.0 - initial release
// ============================================================================
package rearrange_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_PASS  = 2'd0;
    localparam mode_t MODE_BSWAP = 2'd1;
    localparam mode_t MODE_BREV  = 2'd2;
    localparam mode_t MODE_FULL  = 2'd3;

endpackage : rearrange_pkg
`default_nettype wire

// File: rtl/rearrange_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : rearrange_stream_if
// Description : Input/output stream bundle of the rearranger, with modports.
// Revision    : 1.0 - initial release
// ============================================================================
interface rearrange_stream_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) ();
    import rearrange_pkg::*;

    mode_t              cfg_mode;
    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               out_last;
    logic               out_ready;
    logic [CNT_W-1:0]   out_idx;
    logic               frame_active;

    modport master (
        output cfg_mode, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_idx, frame_active
    );

    modport slave (
        input  cfg_mode, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_idx, frame_active
    );

endinterface : rearrange_stream_if
`default_nettype wire

// File: rtl/rearrange_stream_lane.sv
`default_nettype none
// ============================================================================
// Module      : rearrange_lane
// Description : Combinational byte swap / per-byte bit reversal of one lane.
// Revision    : 1.0 - initial release
// ============================================================================
module rearrange_lane
    import rearrange_pkg::*;
#(
    parameter int LANE_W = 32
) (
    input  wire logic [LANE_W-1:0] data_i,
    input  wire mode_t             mode_i,
    output logic      [LANE_W-1:0] data_o
);

    localparam int N_BYTES = LANE_W / 8;

    logic w_bswap;
    logic w_brev;

    assign w_bswap = (mode_i == MODE_BSWAP) || (mode_i == MODE_FULL);
    assign w_brev  = (mode_i == MODE_BREV)  || (mode_i == MODE_FULL);

    // Each output bit picks its source byte and source bit independently.
    always_comb begin
        int src_byte;
        int src_bit;
        data_o   = '0;
        src_byte = 0;
        src_bit  = 0;
        for (int k = 0; k < LANE_W; k++) begin
            src_byte  = w_bswap ? (N_BYTES - 1 - (k / 8)) : (k / 8);
            src_bit   = w_brev  ? (7 - (k % 8))           : (k % 8);
            data_o[k] = data_i[src_byte * 8 + src_bit];
        end
    end

endmodule : rearrange_lane
`default_nettype wire

// File: rtl/rearrange_stream.sv
`default_nettype none
// ============================================================================
// Module      : rearrange_stream
// Description : Streaming lane rearranger with frame tracking and skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module rearrange_stream
    import rearrange_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = 32,
    parameter int CNT_W  = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    rearrange_stream_if.slave  s
);

    localparam int N_LANES = DATA_W / LANE_W;

    logic               frame_active_q, frame_active_d;
    mode_t              mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               out_valid_q;
    logic               out_last_q;
    logic [DATA_W-1:0]  out_data_q;
    logic [CNT_W-1:0]   out_idx_q;

    logic               skid_full_q;
    logic               skid_last_q;
    logic [DATA_W-1:0]  skid_data_q;
    logic [CNT_W-1:0]   skid_idx_q;

    logic               w_accept;
    logic               w_first;
    logic               w_out_free;
    mode_t              w_mode;
    logic [CNT_W-1:0]   w_idx;
    logic [DATA_W-1:0]  w_data;

    assign w_accept   = s.in_valid & ~skid_full_q;
    assign w_first    = ~frame_active_q;
    assign w_out_free = ~out_valid_q | s.out_ready;
    assign w_mode     = w_first ? s.cfg_mode : mode_q;
    assign w_idx      = w_first ? '0 : cnt_q;

    generate
        for (genvar g = 0; g < N_LANES; g++) begin : g_lane
            rearrange_lane #(.LANE_W(LANE_W)) u_lane (
                .data_i (s.in_data[g*LANE_W +: LANE_W]),
                .mode_i (w_mode),
                .data_o (w_data[g*LANE_W +: LANE_W])
            );
        end
    endgenerate

    always_comb begin
        frame_active_d = frame_active_q;
        mode_d         = mode_q;
        cnt_d          = cnt_q;
        if (w_accept) begin
            frame_active_d = ~s.in_last;
            mode_d         = w_mode;
            cnt_d          = w_idx + CNT_W'(1);
        end
    end

    // Skid contents always drain to the output first to preserve beat order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_active_q <= 1'b0;
            mode_q         <= MODE_PASS;
            cnt_q          <= '0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            out_data_q     <= '0;
            out_idx_q      <= '0;
            skid_full_q    <= 1'b0;
            skid_last_q    <= 1'b0;
            skid_data_q    <= '0;
            skid_idx_q     <= '0;
        end else begin
            frame_active_q <= frame_active_d;
            mode_q         <= mode_d;
            cnt_q          <= cnt_d;
            if (w_out_free) begin
                if (skid_full_q) begin
                    out_valid_q <= 1'b1;
                    out_last_q  <= skid_last_q;
                    out_data_q  <= skid_data_q;
                    out_idx_q   <= skid_idx_q;
                    skid_full_q <= 1'b0;
                end else if (w_accept) begin
                    out_valid_q <= 1'b1;
                    out_last_q  <= s.in_last;
                    out_data_q  <= w_data;
                    out_idx_q   <= w_idx;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (w_accept) begin
                skid_full_q <= 1'b1;
                skid_last_q <= s.in_last;
                skid_data_q <= w_data;
                skid_idx_q  <= w_idx;
            end
        end
    end

    assign s.in_ready     = ~skid_full_q;
    assign s.out_valid    = out_valid_q;
    assign s.out_last     = out_last_q;
    assign s.out_data     = out_data_q;
    assign s.out_idx      = out_idx_q;
    assign s.frame_active = frame_active_q;

endmodule : rearrange_stream
`default_nettype wire

// File: tb/tb_rearrange_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_rearrange_stream
// Description : Self-checking bench with directed cases and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rearrange_stream;
    import rearrange_pkg::*;

    localparam int DW = 64;
    localparam int LW = 32;
    localparam int CW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rearrange_stream_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    rearrange_stream #(.DATA_W(DW), .LANE_W(LW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (bus)
    );

    typedef struct {
        logic [63:0] d;
        logic        l;
        logic [2:0]  idx;
    } beat_t;

    int    n_vec = 0;
    int    n_err = 0;
    beat_t q[$];
    logic       m_in_frame;
    logic [1:0] m_mode;
    logic [2:0] m_idx;
    logic       held_v;
    beat_t      held;
    bit         rnd_done = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Each 32-bit lane treated as a byte array or a bit vector as a whole.
    function automatic logic [63:0] ref_word(input logic [63:0] d, input logic [1:0] m);
        logic [63:0] r;
        logic [31:0] lane, o;
        logic [7:0]  byt;
        r = '0;
        for (int l = 0; l < 2; l++) begin
            lane = d[l*32 +: 32];
            o    = lane;
            case (m)
                2'd1: o = {<<8{lane}};
                2'd2: for (int b = 0; b < 4; b++) begin
                          byt = lane[b*8 +: 8];
                          o[b*8 +: 8] = {<<{byt}};
                      end
                2'd3: o = {<<{lane}};
                default: o = lane;
            endcase
            r[l*32 +: 32] = o;
        end
        return r;
    endfunction

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_in_frame = 1'b0;
            m_mode     = 2'd0;
            m_idx      = 3'd0;
            held_v     = 1'b0;
        end else begin
            beat_t e;
            chk("frame_active", 64'(bus.frame_active), 64'(m_in_frame));
            chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
            if (held_v) begin
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_data", bus.out_data, held.d);
                chk("hold_idx", 64'(bus.out_idx), 64'(held.idx));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("sb_data", bus.out_data, e.d);
                    chk("sb_last", 64'(bus.out_last), 64'(e.l));
                    chk("sb_idx", 64'(bus.out_idx), 64'(e.idx));
                end
            end
            held_v = bus.out_valid && !bus.out_ready;
            held.d = bus.out_data;
            held.l = bus.out_last;
            held.idx = bus.out_idx;
            if (bus.in_valid && bus.in_ready) begin
                logic [1:0] md;
                logic [2:0] ix;
                md = m_in_frame ? m_mode : bus.cfg_mode;
                ix = m_in_frame ? m_idx : 3'd0;
                e.d = ref_word(bus.in_data, md);
                e.l = bus.in_last;
                e.idx = ix;
                q.push_back(e);
                m_mode     = md;
                m_idx      = ix + 3'd1;
                m_in_frame = !bus.in_last;
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic l, input logic [1:0] m);
        bit ok;
        ok = 0;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.cfg_mode = m;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic gap(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] mexp [4];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        mexp[0] = 32'h11223344; mexp[1] = 32'h44332211;
        mexp[2] = 32'h8844CC22; mexp[3] = 32'h22CC4488;
        bus.cfg_mode = 2'd0; bus.in_data = '0; bus.in_valid = 1'b0;
        bus.in_last = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_idx", 64'(bus.out_idx), 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_frame_active", 64'(bus.frame_active), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        for (int m = 0; m < 4; m++) begin
            send(64'h11223344_11223344, 1'b1, 2'(m));
            bus.in_valid = 1'b0;
            chk("mode_valid", 64'(bus.out_valid), 64'd1);
            chk("mode_data", bus.out_data, {mexp[m], mexp[m]});
            gap(1);
        end

        send(64'h01020304_05060708, 1'b1, 2'd1);
        bus.in_valid = 1'b0;
        chk("lane_bswap", bus.out_data, 64'h04030201_08070605);
        gap(2);

        for (int i = 0; i < 4; i++) begin
            send(64'h00000001_00000001, i == 3, (i >= 2) ? 2'd0 : 2'd3);
            chk("latch_data", bus.out_data, 64'h80000000_80000000);
            chk("latch_idx", 64'(bus.out_idx), 64'(i));
            chk("latch_last", 64'(bus.out_last), 64'(i == 3));
            chk("latch_frame", 64'(bus.frame_active), 64'(i != 3));
        end
        gap(2);

        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(64'(i), i == 5, 2'd0);
                bus.in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    chk("bp_stream", 64'(bus.out_valid), 64'd1);
                end
            end
        join
        gap(3);

        bus.out_ready = 1'b0;
        send(64'hAAAA5555_12345678, 1'b0, 2'd1);
        send(64'h0F0F0F0F_F0F0F0F0, 1'b0, 2'd1);
        bus.in_data = 64'hDEADBEEF_CAFEF00D;
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mrst_out_idx", 64'(bus.out_idx), 64'd0);
        chk("mrst_frame", 64'(bus.frame_active), 64'd0);
        chk("mrst_in_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0;
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(64'h11223344_01020304, 1'b1, 2'd2);
        bus.in_valid = 1'b0;
        chk("mrst_first_idx", 64'(bus.out_idx), 64'd0);
        chk("mrst_first_data", bus.out_data, 64'h8844CC22_8040C020);
        gap(2);

        for (int i = 0; i < 10; i++) begin
            send({$urandom, $urandom}, i == 9, 2'($urandom_range(0, 3)));
            chk("wrap_idx", 64'(bus.out_idx), 64'(i % 8));
        end
        gap(2);

        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
                    send({$urandom, $urandom}, $urandom_range(0, 4) == 0,
                         2'($urandom_range(0, 3)));
                end
                bus.in_valid = 1'b0;
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", 64'(q.size()), 64'd0);
        chk("drain_valid", 64'(bus.out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_rearrange_stream
`default_nettype wire
